// File: rtl/offnariscv_ace_rd_arbiter.sv
// Round-robin arbiter that lets NUM_REQ read ports share one ACE AR/R port, one burst in flight.
// Latency: AR accepted at T appears on m_ar* at T+1. R is zero-latency passthrough that follows m_rvalid/s_rready.
module offnariscv_ace_rd_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int ID_WIDTH      = 1,
  parameter int AXLEN_WIDTH   = 8,
  parameter int AXSIZE_WIDTH  = 3,
  parameter int AXBURST_WIDTH = 2,
  parameter int ARSNOOP_WIDTH = 4,
  parameter int RRESP_WIDTH   = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQ-1:0]                           s_arvalid,
  output logic [NUM_REQ-1:0]                           s_arready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]           s_araddr,
  input  logic [NUM_REQ-1:0][AXLEN_WIDTH-1:0]          s_arlen,
  input  logic [NUM_REQ-1:0][AXSIZE_WIDTH-1:0]         s_arsize,
  input  logic [NUM_REQ-1:0][AXBURST_WIDTH-1:0]        s_arburst,
  input  logic [NUM_REQ-1:0][ARSNOOP_WIDTH-1:0]        s_arsnoop,
  output logic [NUM_REQ-1:0]                           s_rvalid,
  input  logic [NUM_REQ-1:0]                           s_rready,
  output logic [DATA_WIDTH-1:0]                        s_rdata,
  output logic [RRESP_WIDTH-1:0]                       s_rresp,
  output logic                                         s_rlast,
  output logic                                         m_arvalid,
  input  logic                                         m_arready,
  output logic [ID_WIDTH-1:0]                          m_arid,
  output logic [ADDR_WIDTH-1:0]                        m_araddr,
  output logic [AXLEN_WIDTH-1:0]                       m_arlen,
  output logic [AXSIZE_WIDTH-1:0]                      m_arsize,
  output logic [AXBURST_WIDTH-1:0]                     m_arburst,
  output logic [ARSNOOP_WIDTH-1:0]                     m_arsnoop,
  input  logic                                         m_rvalid,
  output logic                                         m_rready,
  input  logic [DATA_WIDTH-1:0]                        m_rdata,
  input  logic [RRESP_WIDTH-1:0]                       m_rresp,
  input  logic                                         m_rlast
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state, state_nxt;
  logic [IDX_WIDTH-1:0]   gnt_q, rr_last, pick;
  logic                   any_req, accept, burst_done;

  // Search starts just after the last winner, so every requester is reached within NUM_REQ grants.
  always_comb begin
    logic [IDX_WIDTH-1:0] idx;
    any_req = 1'b0;
    pick    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_WIDTH'((int'(rr_last) + k) % NUM_REQ);
      if (!any_req && s_arvalid[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_arready  = '0;
    m_arvalid  = 1'b0;
    s_rvalid   = '0;
    m_rready   = 1'b0;
    accept     = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          accept          = 1'b1;
          // Gated so that a requester holding arvalid through reset never sees ready.
          s_arready[pick] = rst_n;
          state_nxt       = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        s_rvalid[gnt_q] = m_rvalid;
        m_rready        = s_rready[gnt_q];
        if (m_rvalid && s_rready[gnt_q] && m_rlast) begin
          burst_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      rr_last   <= IDX_WIDTH'(NUM_REQ - 1);
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arsnoop <= '0;
    end else begin
      if (accept) begin
        gnt_q     <= pick;
        m_araddr  <= s_araddr[pick];
        m_arlen   <= s_arlen[pick];
        m_arsize  <= s_arsize[pick];
        m_arburst <= s_arburst[pick];
        m_arsnoop <= s_arsnoop[pick];
      end
      if (burst_done) rr_last <= gnt_q;
    end
  end

  assign m_arid  = ID_WIDTH'(gnt_q);
  assign s_rdata = (state == DATA) ? m_rdata : '0;
  assign s_rresp = (state == DATA) ? m_rresp : '0;
  assign s_rlast = (state == DATA) ? m_rlast : 1'b0;

endmodule

// File: tb/tb_offnariscv_ace_rd_arbiter.sv
// Bench for offnariscv_ace_rd_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_offnariscv_ace_rd_arbiter;

  logic             clk, rst_n;
  logic [1:0]       s_arvalid, s_arready;
  logic [1:0][31:0] s_araddr;
  logic [1:0][7:0]  s_arlen;
  logic [1:0][2:0]  s_arsize;
  logic [1:0][1:0]  s_arburst;
  logic [1:0][3:0]  s_arsnoop;
  logic [1:0]       s_rvalid, s_rready;
  logic [63:0]      s_rdata;
  logic [3:0]       s_rresp;
  logic             s_rlast;
  logic             m_arvalid, m_arready;
  logic [0:0]       m_arid;
  logic [31:0]      m_araddr;
  logic [7:0]       m_arlen;
  logic [2:0]       m_arsize;
  logic [1:0]       m_arburst;
  logic [3:0]       m_arsnoop;
  logic             m_rvalid, m_rready;
  logic [63:0]      m_rdata;
  logic [3:0]       m_rresp;
  logic             m_rlast;

  offnariscv_ace_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arsnoop(s_arsnoop),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arsnoop(m_arsnoop),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: who owns the port, whether its AR is still pending, and the fairness pointer.
  int          owner = -1;
  bit          ar_pending = 1'b0;
  int          rr = 1;
  int          beats_left = 0;
  logic [31:0] ex_addr;
  logic [7:0]  ex_len;
  logic [2:0]  ex_size;
  logic [1:0]  ex_burst;
  logic [3:0]  ex_snoop;
  int          ex_id;
  int          dut_beats[2];
  int          ar_ids[$];

  // Inputs are set at the negedge before this is called; checks run 1 time unit later.
  task automatic step();
    logic [1:0] e_arready, e_rvalid;
    logic       e_arvalid, e_rready;
    int         g;
    bit         data;
    data = (owner >= 0) && !ar_pending;
    if (data && rst_n) m_rlast = (beats_left == 1);
    #1;
    if (!rst_n) begin
      check("rst_arready", 64'(s_arready), 64'd0);
      check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
      check("rst_m_arid", 64'(m_arid), 64'd0);
      check("rst_m_araddr", 64'(m_araddr), 64'd0);
      check("rst_m_arlen", 64'(m_arlen), 64'd0);
      check("rst_s_rvalid", 64'(s_rvalid), 64'd0);
      check("rst_m_rready", 64'(m_rready), 64'd0);
      check("rst_s_rdata", s_rdata, 64'd0);
      check("rst_s_rlast", 64'(s_rlast), 64'd0);
      owner = -1; ar_pending = 1'b0; rr = 1;
    end else begin
      g = -1;
      if (owner < 0)
        for (int k = 1; k <= 2; k++) begin
          int i = (rr + k) % 2;
          if (g < 0 && ((s_arvalid >> i) & 2'd1) != 2'd0) g = i;
        end
      e_arready = (g >= 0) ? 2'(1 << g) : 2'd0;
      e_arvalid = (owner >= 0) && ar_pending;
      e_rvalid  = (data && m_rvalid) ? 2'(1 << owner) : 2'd0;
      e_rready  = data && (((s_rready >> owner) & 2'd1) != 2'd0);
      check("s_arready", 64'(s_arready), 64'(e_arready));
      check("m_arvalid", 64'(m_arvalid), 64'(e_arvalid));
      check("s_rvalid", 64'(s_rvalid), 64'(e_rvalid));
      check("m_rready", 64'(m_rready), 64'(e_rready));
      if (e_arvalid) begin
        check("m_arid", 64'(m_arid), 64'(ex_id));
        check("m_araddr", 64'(m_araddr), 64'(ex_addr));
        check("m_arlen", 64'(m_arlen), 64'(ex_len));
        check("m_arsize", 64'(m_arsize), 64'(ex_size));
        check("m_arburst", 64'(m_arburst), 64'(ex_burst));
        check("m_arsnoop", 64'(m_arsnoop), 64'(ex_snoop));
      end
      if (data && m_rvalid) begin
        check("s_rdata", s_rdata, m_rdata);
        check("s_rresp", 64'(s_rresp), 64'(m_rresp));
        check("s_rlast", 64'(s_rlast), 64'(m_rlast));
      end
      if (s_rvalid[0] && s_rready[0]) dut_beats[0]++;
      if (s_rvalid[1] && s_rready[1]) dut_beats[1]++;
      if (g >= 0) begin
        owner = g; ar_pending = 1'b1; ex_id = g;
        ex_addr = s_araddr[g[0]]; ex_len = s_arlen[g[0]]; ex_size = s_arsize[g[0]];
        ex_burst = s_arburst[g[0]]; ex_snoop = s_arsnoop[g[0]];
      end else if (e_arvalid && m_arready) begin
        ar_ids.push_back(ex_id);
        ar_pending = 1'b0;
        beats_left = int'(ex_len) + 1;
      end else if (e_rready && m_rvalid) begin
        beats_left--;
        if (m_rlast) begin rr = owner; owner = -1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arsnoop = '0;
    s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    dut_beats[0] = 0; dut_beats[1] = 0;
    ar_ids.delete();
  endtask

  task automatic drain();
    m_arready = 1'b1; m_rvalid = 1'b1; s_rready = 2'b11; s_arvalid = '0;
    for (int c = 0; c < 40 && owner >= 0; c++) step();
    check("drain_idle", 64'(owner < 0), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);

    // Reset, then quiet idle cycles.
    do_reset();
    repeat (3) step();

    // Single request from requester 1.
    idle_inputs(); do_reset();
    s_arvalid = 2'b10; s_araddr[1] = 32'h8000_0040; s_arlen[1] = 8'd3; s_arsize[1] = 3'd3; s_arburst[1] = 2'd1;
    #1 check("t2_arready", 64'(s_arready), 64'd2);
    step();
    s_arvalid = '0;
    #1 check("t2_m_arvalid", 64'(m_arvalid), 64'd1);
    check("t2_m_arid", 64'(m_arid), 64'd1);
    check("t2_m_araddr", 64'(m_araddr), 64'h8000_0040);
    m_arready = 1'b1; step();
    m_rvalid = 1'b1; s_rready = 2'b11;
    for (int c = 0; c < 20 && owner >= 0; c++) begin m_rdata = {$urandom, $urandom}; step(); end
    check("t2_beats1", 64'(dut_beats[1]), 64'd4);
    check("t2_beats0", 64'(dut_beats[0]), 64'd0);
    m_rvalid = 1'b0; s_arvalid = 2'b01;
    #1 check("t2_idle_after_last", 64'(s_arready), 64'd1);
    step(); drain();

    // Both requesters held high from reset: grants alternate.
    idle_inputs();
    s_arvalid = 2'b11; m_arready = 1'b1; m_rvalid = 1'b1; s_rready = 2'b11;
    do_reset();
    for (int c = 0; c < 40 && ar_ids.size() < 4; c++) step();
    check("t3_count", 64'(ar_ids.size() >= 4), 64'd1);
    if (ar_ids.size() >= 4)
      for (int i = 0; i < 4; i++) check("t3_gnt_seq", 64'(ar_ids[i]), 64'(i % 2));
    drain();

    // AR backpressure for 5 cycles.
    idle_inputs(); do_reset();
    s_arvalid = 2'b01; s_araddr[0] = 32'h1234_5678; s_arlen[0] = 8'd1; s_arsnoop[0] = 4'h2;
    step();
    s_arvalid = '0;
    for (int c = 0; c < 5; c++) begin
      #1 check("t4_hold_valid", 64'(m_arvalid), 64'd1);
      check("t4_hold_addr", 64'(m_araddr), 64'h1234_5678);
      step();
    end
    drain();

    // R backpressure on beat 2 of a 4-beat burst.
    idle_inputs(); do_reset();
    s_arvalid = 2'b01; s_arlen[0] = 8'd3; m_arready = 1'b1;
    step();
    s_arvalid = '0; step();
    m_rvalid = 1'b1;
    begin
      int stall = 0;
      for (int c = 0; c < 30 && owner >= 0; c++) begin
        m_rdata = {$urandom, $urandom};
        if (dut_beats[0] == 1 && stall < 3) begin
          s_rready = 2'b00;
          #1 check("t5_m_rready_low", 64'(m_rready), 64'd0);
          stall++;
        end else s_rready = 2'b01;
        step();
      end
    end
    check("t5_beats", 64'(dut_beats[0]), 64'd4);

    // Reset after the first beat of a burst.
    idle_inputs(); do_reset();
    s_arvalid = 2'b01; s_arlen[0] = 8'd3; m_arready = 1'b1;
    step();
    s_arvalid = '0; step();
    m_rvalid = 1'b1; s_rready = 2'b01; step();
    rst_n = 1'b0;
    #1 check("t6_rvalid", 64'(s_rvalid), 64'd0);
    check("t6_m_rready", 64'(m_rready), 64'd0);
    step();
    rst_n = 1'b1; m_rvalid = 1'b0; s_arvalid = 2'b11; s_arlen = '0;
    #1 check("t6_prio", 64'(s_arready), 64'd1);
    step(); drain();

    // Random traffic, including stray R beats, error responses and dropped requests.
    idle_inputs(); do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_arvalid = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        s_araddr[r] = $urandom; s_arlen[r] = 8'($urandom_range(0, 3)); s_arsize[r] = 3'($urandom);
        s_arburst[r] = 2'($urandom); s_arsnoop[r] = 4'($urandom);
      end
      m_arready = ($urandom % 3) != 0;
      m_rvalid  = ($urandom % 2) != 0;
      s_rready  = 2'($urandom);
      m_rdata   = {$urandom, $urandom};
      m_rresp   = 4'($urandom);
      m_rlast   = ($urandom % 2) != 0;
      rst_n     = ($urandom % 500) != 0;
      step();
      rst_n = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
